// File: rtl/jpeg_scan_packer.sv
// rtl/jpeg_scan_packer.sv - JPEG scan-data packer: code words to bytes, 0xFF stuffing, 1-padding, optional EOI
module jpeg_scan_packer #(
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [MAX_LEN-1:0] in_bits,
  input  logic [LEN_W-1:0]   in_len,
  input  logic               flush_req,
  input  logic               flush_eoi,
  output logic               flush_done,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         out_byte,
  output logic               out_marker,
  output logic               busy
);

  localparam int ACC_W = MAX_LEN + 7;
  localparam int CNT_W = $clog2(MAX_LEN + 8);

  typedef enum logic [2:0] {RUN, STUFF, PAD, EOI_FF, EOI_D9, DONE} state_t;

  state_t             state, state_nx;
  logic [ACC_W-1:0]   acc, acc_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic               eoi, eoi_nx;
  logic               pad_ret, pad_ret_nx;

  logic [LEN_W-1:0]   len_sat;
  logic [MAX_LEN-1:0] in_masked;
  logic [7:0]         win;
  logic               have_byte;

  assign len_sat   = (in_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : in_len;
  assign in_masked = in_bits & ~({MAX_LEN{1'b1}} << len_sat);
  // Top 8 bits of the valid region; below cnt=8 the window runs into the 1s pad
  assign win       = 8'({acc, 8'hFF} >> cnt);
  assign have_byte = (cnt >= CNT_W'(8));
  assign busy      = (cnt != '0) || (state != RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      acc     <= '0;
      cnt     <= '0;
      eoi     <= 1'b0;
      pad_ret <= 1'b0;
    end else begin
      state   <= state_nx;
      acc     <= acc_nx;
      cnt     <= cnt_nx;
      eoi     <= eoi_nx;
      pad_ret <= pad_ret_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    acc_nx     = acc;
    cnt_nx     = cnt;
    eoi_nx     = eoi;
    pad_ret_nx = pad_ret;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_byte   = win;
    out_marker = 1'b0;
    flush_done = 1'b0;
    case (state)
      RUN: begin
        in_ready  = !have_byte && !flush_req && !rst;
        out_valid = have_byte;
        if (in_valid && in_ready) begin
          acc_nx = (acc << len_sat) | ACC_W'(in_masked);
          cnt_nx = cnt + CNT_W'(len_sat);
        end
        if (flush_req) begin
          eoi_nx     = flush_eoi;
          pad_ret_nx = 1'b1;
          state_nx   = PAD;
        end
        // A 0xFF overrides the PAD transition; pad_ret brings STUFF back to PAD
        if (have_byte && out_ready) begin
          cnt_nx = cnt - CNT_W'(8);
          if (win == 8'hFF) state_nx = STUFF;
        end
      end
      STUFF: begin
        out_valid = 1'b1;
        out_byte  = 8'h00;
        if (out_ready) state_nx = pad_ret ? PAD : RUN;
      end
      PAD: begin
        if (cnt != '0) begin
          out_valid = 1'b1;
          if (out_ready) begin
            cnt_nx = have_byte ? cnt - CNT_W'(8) : '0;
            if (win == 8'hFF) state_nx = STUFF;
          end
        end else begin
          state_nx = eoi ? EOI_FF : DONE;
        end
      end
      EOI_FF: begin
        out_valid  = 1'b1;
        out_byte   = 8'hFF;
        out_marker = 1'b1;
        if (out_ready) state_nx = EOI_D9;
      end
      EOI_D9: begin
        out_valid  = 1'b1;
        out_byte   = 8'hD9;
        out_marker = 1'b1;
        if (out_ready) state_nx = DONE;
      end
      DONE: begin
        flush_done = 1'b1;
        acc_nx     = '0;
        cnt_nx     = '0;
        eoi_nx     = 1'b0;
        pad_ret_nx = 1'b0;
        state_nx   = RUN;
      end
      default: state_nx = RUN;
    endcase
  end

endmodule

// File: tb/tb_jpeg_scan_packer.sv
// tb/tb_jpeg_scan_packer.sv - self-checking bench for jpeg_scan_packer
module tb_jpeg_scan_packer;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush_req, flush_eoi, flush_done;
  logic        out_valid, out_ready, out_marker, busy;
  logic [31:0] in_bits;
  logic [5:0]  in_len;
  logic [7:0]  out_byte;

  jpeg_scan_packer #(.MAX_LEN(32), .LEN_W(6)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_bits(in_bits), .in_len(in_len), .flush_req(flush_req), .flush_eoi(flush_eoi),
    .flush_done(flush_done), .out_valid(out_valid), .out_ready(out_ready),
    .out_byte(out_byte), .out_marker(out_marker), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  bit mon_en = 1'b1;
  bit bp_mode = 1'b0;

  logic [8:0] got[$];
  logic [8:0] exp_q[$];
  bit         ref_bits[$];

  typedef struct {
    logic [31:0] b0; int l0;
    logic [31:0] b1; int l1;
    bit fl; bit eoi;
    int n; logic [39:0] eb; logic [4:0] mk;
  } vec_t;
  vec_t tv[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (mon_en && out_valid && out_ready) got.push_back({out_marker, out_byte});
      if (flush_done === 1'b1) done_cnt++;
    end
  end

  always @(posedge clk) begin
    #1;
    if (bp_mode) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Reference: a flat bit stream cut into bytes, with stuffing and padding rules
  function automatic void model_emit();
    logic [7:0] b;
    while (ref_bits.size() >= 8) begin
      b = '0;
      for (int k = 0; k < 8; k++) b = {b[6:0], ref_bits.pop_front()};
      exp_q.push_back({1'b0, b});
      if (b == 8'hFF) exp_q.push_back(9'h000);
    end
  endfunction

  function automatic void model_word(input logic [31:0] b, input int l);
    int n = (l > 32) ? 32 : l;
    for (int i = n - 1; i >= 0; i--) ref_bits.push_back(b[i]);
    model_emit();
  endfunction

  function automatic void model_flush(input bit e);
    if (ref_bits.size() > 0) begin
      while (ref_bits.size() % 8 != 0) ref_bits.push_back(1'b1);
      model_emit();
    end
    if (e) begin
      exp_q.push_back(9'h1FF);
      exp_q.push_back(9'h1D9);
    end
  endfunction

  task automatic send_word(input logic [31:0] b, input int l);
    int n = 0;
    in_valid = 1'b1; in_bits = b; in_len = 6'(l);
    while (1) begin
      @(negedge clk);
      if (in_ready) begin tick(); break; end
      tick();
      n++;
      if (n > 300) begin chk("send_word timeout", 1, 0); break; end
    end
    in_valid = 1'b0; in_bits = '0; in_len = '0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (1) begin
      @(negedge clk);
      if (!out_valid) begin tick(); break; end
      tick();
      n++;
      if (n > 300) begin chk({tag, " drain timeout"}, 1, 0); break; end
    end
  endtask

  task automatic do_flush(input bit e);
    int d0, n;
    wait_idle("flush");
    d0 = done_cnt;
    flush_req = 1'b1; flush_eoi = e;
    tick();
    flush_req = 1'b0; flush_eoi = 1'b0;
    n = 0;
    while (done_cnt == d0) begin
      tick();
      n++;
      if (n > 300) begin chk("flush_done timeout", 1, 0); break; end
    end
  endtask

  task automatic cmp_stream(input string tag);
    chk({tag, " count"}, got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      chk($sformatf("%s byte%0d", tag, i), got[i], exp_q[i]);
    got.delete();
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, nfl;
    bit e;
    rst = 1'b1; in_valid = 0; in_bits = 0; in_len = 0;
    flush_req = 0; flush_eoi = 0; out_ready = 1'b1;

    tv[0] = '{32'h5,        3,  32'h1E,       5, 1'b0, 1'b0, 1, 40'hBE_00_00_00_00, 5'b00000};
    tv[1] = '{32'hFF,       8,  32'h12,       8, 1'b0, 1'b0, 3, 40'hFF_00_12_00_00, 5'b00000};
    tv[2] = '{32'h2,        3,  32'hFFFF_FFFF, 0, 1'b1, 1'b1, 3, 40'h5F_FF_D9_00_00, 5'b01100};
    tv[3] = '{32'h1F,       5,  32'h0,        0, 1'b1, 1'b0, 2, 40'hFF_00_00_00_00, 5'b00000};
    tv[4] = '{32'h0,        0,  32'h0,        0, 1'b1, 1'b0, 0, 40'h0,              5'b00000};
    tv[5] = '{32'hA5A5_A5A5, 63, 32'h0,        0, 1'b0, 1'b0, 4, 40'hA5_A5_A5_A5_00, 5'b00000};
    tv[6] = '{32'hFFFF_FF0F, 4,  32'hFFFF_FFF0, 4, 1'b0, 1'b0, 1, 40'hF0_00_00_00_00, 5'b00000};
    tv[7] = '{32'h7F,       7,  32'h0,        0, 1'b1, 1'b1, 4, 40'hFF_00_FF_D9_00, 5'b00110};

    // reset held for two edges
    tick();
    @(negedge clk); chk("in_ready during rst", in_ready, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("reset out_valid", out_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset flush_done", flush_done, 0);
    chk("reset in_ready", in_ready, 1);
    tick();

    for (int v = 0; v < 8; v++) begin
      d0 = done_cnt;
      send_word(tv[v].b0, tv[v].l0);
      send_word(tv[v].b1, tv[v].l1);
      if (tv[v].fl) do_flush(tv[v].eoi);
      else wait_idle($sformatf("vec%0d", v));
      for (int k = 0; k < tv[v].n; k++)
        exp_q.push_back({tv[v].mk[4-k], tv[v].eb[39-8*k -: 8]});
      cmp_stream($sformatf("vec%0d", v));
      @(negedge clk);
      chk($sformatf("vec%0d busy", v), busy, 0);
      chk($sformatf("vec%0d done", v), done_cnt - d0, tv[v].fl ? 1 : 0);
      tick();
    end

    // flush with nothing buffered: flush_done two cycles later
    flush_req = 1'b1; flush_eoi = 1'b0;
    tick();
    flush_req = 1'b0;
    @(negedge clk);
    chk("empty flush c1 done", flush_done, 0);
    chk("empty flush c1 busy", busy, 1);
    tick();
    @(negedge clk);
    chk("empty flush c2 done", flush_done, 1);
    chk("empty flush c2 valid", out_valid, 0);
    tick();
    @(negedge clk);
    chk("empty flush c3 busy", busy, 0);
    tick();

    // flush_req together with a 0xFF byte accept: stuff first, then pad
    out_ready = 1'b0;
    send_word(32'hFF, 8);
    tick();
    d0 = done_cnt;
    out_ready = 1'b1; flush_req = 1'b1; flush_eoi = 1'b1;
    tick();
    flush_req = 1'b0; flush_eoi = 1'b0;
    for (int n = 0; n < 50 && done_cnt == d0; n++) tick();
    exp_q.push_back(9'h0FF); exp_q.push_back(9'h000);
    exp_q.push_back(9'h1FF); exp_q.push_back(9'h1D9);
    cmp_stream("ff+flush");
    chk("ff+flush done", done_cnt - d0, 1);

    // backpressure hold, then reset while in STUFF
    mon_en = 1'b0;
    out_ready = 1'b0;
    send_word(32'hFF, 8);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("bp%0d hold", c), {out_valid, out_marker, out_byte, in_ready}, {1'b1, 1'b0, 8'hFF, 1'b0});
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    chk("bp stuff byte", {out_valid, out_marker, out_byte}, {1'b1, 1'b0, 8'h00});
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst in stuff valid", out_valid, 0);
    chk("rst in stuff busy", busy, 0);
    tick();
    out_ready = 1'b1;
    got.delete();
    mon_en = 1'b1;

    // randomized stream against the bit-queue reference
    ref_bits.delete(); exp_q.delete();
    d0 = done_cnt; nfl = 0;
    bp_mode = 1'b1;
    for (int w = 0; w < 300; w++) begin
      logic [31:0] b;
      int l;
      b = $urandom();
      if ($urandom_range(0, 3) == 0) b = b | 32'hFF00_FF00;
      l = $urandom_range(0, 40);
      send_word(b, l);
      model_word(b, l);
      if ($urandom_range(0, 14) == 0) begin
        e = $urandom_range(0, 1);
        do_flush(e);
        model_flush(e);
        nfl++;
      end
      repeat ($urandom_range(0, 2)) tick();
    end
    e = $urandom_range(0, 1);
    do_flush(e);
    model_flush(e);
    nfl++;
    bp_mode = 1'b0;
    tick();
    out_ready = 1'b1;
    cmp_stream("random");
    chk("random flush count", done_cnt - d0, nfl);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
